pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter stage that consumes the 17-bit next-PC produced by the branch-selection mux and registers it as the architectural PC each cycle. It provides the PC+1 and return-address values that feed back into the mux inputs, and owns a small return-address stack (RAS) for call/return. It also sequences boot, stall and halt for the single-cycle core.

## Interface
- PC_WIDTH, 17, width of every address in this block
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2)
- RESET_VECTOR, 17'd0, PC value after reset and RAS underflow return value
- clk  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- next_pc_in  in  PC_WIDTH  selected next PC from branch-selection mux
- stall  in  1  hold PC and RAS this cycle
- halt_req  in  1  enter HALT at next edge
- call  in  1  push pc_plus1 onto RAS on the updating edge
- ret  in  1  pop RAS on the updating edge
- pc_out  out  PC_WIDTH  registered current PC
- pc_plus1  out  PC_WIDTH  pc_out+1 (mux input for sequential flow)
- ret_addr  out  PC_WIDTH  RAS top, or RESET_VECTOR when empty (mux input for return)
- fetch_valid  out  1  high in RUN when not stalled
- halted  out  1  high in HALT
- ras_overflow  out  1  sticky: push while full occurred
- ras_underflow  out  1  sticky: pop while empty occurred

## Operation
- FSM states: BOOT, RUN, HALT. Reset → BOOT.
- BOOT: pc_out = RESET_VECTOR, fetch_valid 0; unconditionally → RUN at next edge, no PC load.
- RUN: at an edge with stall=0, pc_out ← next_pc_in; call/ret act. With stall=1, pc_out, RAS, and flags hold; call/ret ignored.
- RUN → HALT when halt_req=1 at an edge, regardless of stall. That edge performs no PC load and no RAS action. HALT exits only via reset.
- halt_req in BOOT/HALT is ignored.
- pc_plus1 = (pc_out + 1) mod 2^PC_WIDTH; 0x1FFFF wraps to 0x00000.
- The RAS is a circular buffer with top pointer and count (0..RAS_DEPTH).
- Push while full: overwrite oldest entry, count stays RAS_DEPTH, set ras_overflow.
- Pop while empty: count stays 0, set ras_underflow. ret_addr is RESET_VECTOR.
- call and ret on the same edge: the top entry is replaced with pc_plus1 and count is unchanged. No flag is set unless count=0; in that case it acts as a push, with no underflow.
- Sticky flags clear only on reset.

## Timing
- Reset values:
  - pc_out = RESET_VECTOR, pc_plus1 = RESET_VECTOR+1, ret_addr = RESET_VECTOR
  - fetch_valid = 0, halted = 0, flags = 0, count = 0
- Latency: next_pc_in sampled at edge N appears on pc_out after edge N (one register).
- pc_plus1 and ret_addr are combinational from registered state only. No path from next_pc_in, call, or ret to any output, so there is no loop through the mux.
- fetch_valid = (state==RUN) & ~stall, combinational from the stall input.
- Reset asserted mid-cycle clears immediately, regardless of stall/halt. The first RUN cycle is the second edge after reset deassertion.

## Structure
- Shared package/header: state encodings (BOOT=2'd0, RUN=2'd1, HALT=2'd2) and the PC_WIDTH and RESET_VECTOR defaults, reused by the branch-selection mux and fetch stage.
- One sub-module: ras_stack (circular buffer, push/pop/replace, overflow/underflow flags). The FSM and PC register stay in pc_sequencer.

## Test plan
- Reset release: after deassert, pc_out=0 and fetch_valid=0 for one cycle. Then fetch_valid=1, and with next_pc_in=5 pc_out=5 after the following edge.
- Stall: pc_out=0x10, stall=1 for 3 cycles with next_pc_in=0x20 → pc_out stays 0x10 and fetch_valid=0. After stall drops, the next edge gives 0x20.
- Call/return: pc_out=0x30, call=1, next_pc_in=0xC8 → pc_out=0xC8 and ret_addr=0x31. Then ret=1, next_pc_in=ret_addr → pc_out=0x31, ret_addr=0, no flags.
- RAS overflow: 5 pushes from PCs 1..5 (depth 4) → ras_overflow=1. Four pops return 6,5,4,3; a fifth pop sets ras_underflow=1 with ret_addr=0.
- Wrap and simultaneous: pc_out=0x1FFFF → pc_plus1=0. With one entry 0x40, call+ret at pc 0x50 → top=0x51, count 1.
- Halt and async reset: halt_req in RUN → halted=1, pc frozen despite next_pc_in changes. Reset pulse between edges → immediate pc_out=0, halted=0.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer, branch-selection mux and fetch stage:
// default address width, reset vector and sequencer state encodings.
package pc_sequencer_pkg;

   localparam int PC_WIDTH_DEF = 17;
   localparam logic [PC_WIDTH_DEF-1:0] RESET_VECTOR_DEF = 17'd0;

   localparam logic [1:0] ST_BOOT = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack kept as a circular buffer; a full push overwrites the
// oldest entry, an empty pop leaves it empty, and both cases set sticky flags.
module ras_stack #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 4,
   parameter logic [WIDTH-1:0] EMPTY_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top_data,
   output logic             overflow,
   output logic             underflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] entries [DEPTH];
   logic [PW-1:0]    top_ptr;
   logic [PW-1:0]    next_ptr;
   logic [PW-1:0]    prev_ptr;
   logic [CW-1:0]    fill;
   logic             empty;
   logic             full;

   assign next_ptr = top_ptr + 1'b1;
   assign prev_ptr = top_ptr - 1'b1;
   assign empty    = (fill == '0);
   assign full     = (fill == CW'(DEPTH));
   assign top_data = empty ? EMPTY_VALUE : entries[top_ptr];

   // Simultaneous push+pop replaces the top in place, except on an empty
   // stack where it degenerates to a plain push.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
         top_ptr   <= '0;
         fill      <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (push && (!pop || empty)) begin
         entries[next_ptr] <= push_data;
         top_ptr           <= next_ptr;
         if (full) begin
            overflow <= 1'b1;
         end else begin
            fill <= fill + 1'b1;
         end
      end else if (push && pop) begin
         entries[top_ptr] <= push_data;
      end else if (pop) begin
         if (empty) begin
            underflow <= 1'b1;
         end else begin
            top_ptr <= prev_ptr;
            fill    <= fill - 1'b1;
         end
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage: registers the selected next PC, supplies PC+1 and the
// return address back to the branch mux, and sequences boot/run/halt.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int PC_WIDTH = PC_WIDTH_DEF,
   parameter int RAS_DEPTH = 4,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(RESET_VECTOR_DEF)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [PC_WIDTH-1:0] next_pc_in,
   input  logic                stall,
   input  logic                halt_req,
   input  logic                call,
   input  logic                ret,
   output logic [PC_WIDTH-1:0] pc_out,
   output logic [PC_WIDTH-1:0] pc_plus1,
   output logic [PC_WIDTH-1:0] ret_addr,
   output logic                fetch_valid,
   output logic                halted,
   output logic                ras_overflow,
   output logic                ras_underflow
);

   logic [1:0]          state;
   logic [PC_WIDTH-1:0] pc;
   logic                advance;

   // A halting edge performs no PC load and no RAS action, even if unstalled.
   assign advance     = (state == ST_RUN) && !halt_req && !stall;
   assign pc_out      = pc;
   assign pc_plus1    = pc + 1'b1;
   assign fetch_valid = (state == ST_RUN) && !stall;
   assign halted      = (state == ST_HALT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_BOOT;
         pc    <= RESET_VECTOR;
      end else begin
         case (state)
            ST_BOOT: state <= ST_RUN;
            ST_RUN: begin
               if (halt_req) begin
                  state <= ST_HALT;
               end else if (!stall) begin
                  pc <= next_pc_in;
               end
            end
            ST_HALT: state <= ST_HALT;
            default: state <= ST_BOOT;
         endcase
      end
   end

   ras_stack #(
      .WIDTH       (PC_WIDTH),
      .DEPTH       (RAS_DEPTH),
      .EMPTY_VALUE (RESET_VECTOR)
   ) u_ras (
      .clk       (clk),
      .reset     (reset),
      .push      (advance && call),
      .pop       (advance && ret),
      .push_data (pc_plus1),
      .top_data  (ret_addr),
      .overflow  (ras_overflow),
      .underflow (ras_underflow)
   );

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a queue-based reference model checked
// every cycle, plus literal expectations from hand-worked sequences.
module tb_pc_sequencer;

   localparam int W = 17;
   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] next_pc_in = '0;
   logic         stall = 1'b0;
   logic         halt_req = 1'b0;
   logic         call = 1'b0;
   logic         ret = 1'b0;
   logic [W-1:0] pc_out;
   logic [W-1:0] pc_plus1;
   logic [W-1:0] ret_addr;
   logic         fetch_valid;
   logic         halted;
   logic         ras_overflow;
   logic         ras_underflow;

   int errors = 0;
   int checks = 0;
   bit run_checks = 1'b0;

   pc_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .next_pc_in    (next_pc_in),
      .stall         (stall),
      .halt_req      (halt_req),
      .call          (call),
      .ret           (ret),
      .pc_out        (pc_out),
      .pc_plus1      (pc_plus1),
      .ret_addr      (ret_addr),
      .fetch_valid   (fetch_valid),
      .halted        (halted),
      .ras_overflow  (ras_overflow),
      .ras_underflow (ras_underflow)
   );

   always #5 clk = ~clk;

   // Reference model: the RAS is a queue whose back is the top of stack.
   bit           m_booted = 1'b0;
   bit           m_halted = 1'b0;
   bit           m_ovf = 1'b0;
   bit           m_unf = 1'b0;
   logic [W-1:0] m_pc = '0;
   logic [W-1:0] m_ras [$];

   always @(posedge clk or posedge reset) begin
      logic [W-1:0] ret_val;
      if (reset) begin
         m_booted = 1'b0;
         m_halted = 1'b0;
         m_ovf    = 1'b0;
         m_unf    = 1'b0;
         m_pc     = '0;
         m_ras.delete();
      end else if (m_halted) begin
         m_halted = 1'b1;
      end else if (!m_booted) begin
         m_booted = 1'b1;
      end else if (halt_req) begin
         m_halted = 1'b1;
      end else if (!stall) begin
         ret_val = m_pc + 1;
         m_pc = next_pc_in;
         if (call && ret && m_ras.size() > 0) begin
            m_ras[m_ras.size() - 1] = ret_val;
         end else if (call) begin
            m_ras.push_back(ret_val);
            if (m_ras.size() > DEPTH) begin
               void'(m_ras.pop_front());
               m_ovf = 1'b1;
            end
         end else if (ret) begin
            if (m_ras.size() == 0) m_unf = 1'b1;
            else void'(m_ras.pop_back());
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      logic [W-1:0] exp_ret;
      if (run_checks && !reset) begin
         exp_ret = (m_ras.size() > 0) ? m_ras[m_ras.size() - 1] : '0;
         checkOutput("model pc_out", 32'(pc_out), 32'(m_pc));
         checkOutput("model pc_plus1", 32'(pc_plus1), 32'(W'(m_pc + 1)));
         checkOutput("model ret_addr", 32'(ret_addr), 32'(exp_ret));
         checkOutput("model fetch_valid", 32'(fetch_valid), 32'(m_booted && !m_halted && !stall));
         checkOutput("model halted", 32'(halted), 32'(m_halted));
         checkOutput("model ras_overflow", 32'(ras_overflow), 32'(m_ovf));
         checkOutput("model ras_underflow", 32'(ras_underflow), 32'(m_unf));
      end
   end

   // Drive one cycle's inputs just after an edge, then let the next edge take them.
   task automatic applyStimulus(input logic [W-1:0] npc, input logic st, input logic hr,
                                input logic c, input logic r);
      next_pc_in = npc;
      stall      = st;
      halt_req   = hr;
      call       = c;
      ret        = r;
      @(posedge clk);
      #2;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      run_checks = 1'b1;
      #1;
      checkOutput("boot pc_out", 32'(pc_out), 32'h0);
      checkOutput("boot fetch_valid", 32'(fetch_valid), 32'h0);
      checkOutput("boot pc_plus1", 32'(pc_plus1), 32'h1);

      // Boot edge: no load even though next_pc_in is 5.
      applyStimulus(17'd5, 0, 0, 0, 0);
      checkOutput("first run pc_out", 32'(pc_out), 32'h0);
      checkOutput("first run fetch_valid", 32'(fetch_valid), 32'h1);
      applyStimulus(17'd5, 0, 0, 0, 0);
      checkOutput("load 5", 32'(pc_out), 32'h5);

      // Stall holds PC for three cycles.
      applyStimulus(17'h10, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(17'h20, 1, 0, 0, 0);
      checkOutput("stall pc_out", 32'(pc_out), 32'h10);
      checkOutput("stall fetch_valid", 32'(fetch_valid), 32'h0);
      applyStimulus(17'h20, 0, 0, 0, 0);
      checkOutput("unstall pc_out", 32'(pc_out), 32'h20);

      // Call then return.
      applyStimulus(17'h30, 0, 0, 0, 0);
      applyStimulus(17'hC8, 0, 0, 1, 0);
      checkOutput("call pc_out", 32'(pc_out), 32'hC8);
      checkOutput("call ret_addr", 32'(ret_addr), 32'h31);
      applyStimulus(17'h31, 0, 0, 0, 1);
      checkOutput("ret pc_out", 32'(pc_out), 32'h31);
      checkOutput("ret ret_addr", 32'(ret_addr), 32'h0);
      checkOutput("ret no overflow", 32'(ras_overflow), 32'h0);
      checkOutput("ret no underflow", 32'(ras_underflow), 32'h0);

      // Five pushes from PCs 1..5 into a four-deep stack.
      applyStimulus(17'd1, 0, 0, 0, 0);
      for (int i = 2; i <= 6; i++) applyStimulus(W'(i), 0, 0, 1, 0);
      checkOutput("overflow flag", 32'(ras_overflow), 32'h1);
      checkOutput("full top", 32'(ret_addr), 32'h6);
      applyStimulus(17'd6, 0, 0, 0, 1);
      checkOutput("pop1 top", 32'(ret_addr), 32'h5);
      applyStimulus(17'd5, 0, 0, 0, 1);
      checkOutput("pop2 top", 32'(ret_addr), 32'h4);
      applyStimulus(17'd4, 0, 0, 0, 1);
      checkOutput("pop3 top", 32'(ret_addr), 32'h3);
      checkOutput("no underflow yet", 32'(ras_underflow), 32'h0);
      applyStimulus(17'd3, 0, 0, 0, 1);
      checkOutput("pop4 empty top", 32'(ret_addr), 32'h0);
      applyStimulus(17'd0, 0, 0, 0, 1);
      checkOutput("underflow flag", 32'(ras_underflow), 32'h1);
      checkOutput("underflow ret_addr", 32'(ret_addr), 32'h0);

      // Wrap of pc_plus1 at the top of the address space.
      applyStimulus(17'h1FFFF, 0, 0, 0, 0);
      checkOutput("wrap pc_plus1", 32'(pc_plus1), 32'h0);

      // Simultaneous call+ret replaces the single entry.
      applyStimulus(17'h3F, 0, 0, 0, 0);
      applyStimulus(17'h50, 0, 0, 1, 0);
      checkOutput("single entry", 32'(ret_addr), 32'h40);
      applyStimulus(17'h60, 0, 0, 1, 1);
      checkOutput("replaced top", 32'(ret_addr), 32'h51);
      applyStimulus(17'h51, 0, 0, 0, 1);
      checkOutput("count was one", 32'(ret_addr), 32'h0);

      // Call+ret on an empty stack acts as a push.
      applyStimulus(17'h70, 0, 0, 1, 1);
      checkOutput("empty call+ret push", 32'(ret_addr), 32'h52);

      // Halt while stalled, then PC must freeze.
      applyStimulus(17'h80, 1, 1, 1, 0);
      checkOutput("halted", 32'(halted), 32'h1);
      checkOutput("halt pc frozen", 32'(pc_out), 32'h70);
      applyStimulus(17'h99, 0, 0, 0, 1);
      applyStimulus(17'hAA, 0, 1, 1, 0);
      checkOutput("halt hold pc", 32'(pc_out), 32'h70);
      checkOutput("halt fetch_valid", 32'(fetch_valid), 32'h0);
      checkOutput("halt ras hold", 32'(ret_addr), 32'h52);

      // Asynchronous reset between edges.
      #1;
      reset = 1'b1;
      #1;
      checkOutput("async pc_out", 32'(pc_out), 32'h0);
      checkOutput("async halted", 32'(halted), 32'h0);
      checkOutput("async overflow", 32'(ras_overflow), 32'h0);
      checkOutput("async underflow", 32'(ras_underflow), 32'h0);
      checkOutput("async ret_addr", 32'(ret_addr), 32'h0);
      #1;
      reset = 1'b0;
      applyStimulus(17'h123, 0, 0, 0, 0);
      checkOutput("reboot no load", 32'(pc_out), 32'h0);
      applyStimulus(17'h123, 0, 0, 0, 0);
      checkOutput("reboot load", 32'(pc_out), 32'h123);

      @(negedge clk);
      run_checks = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
